// File: rtl/ddr_stream_unpacker.sv
// Unpacks WORD_WIDTH FIFO words into a DATA_WIDTH sample stream with row/frame framing.
// First sample lands two cycles after the read strobe; stall_i gates emission and reads.
module ddr_stream_unpacker #(
  parameter int DATA_WIDTH  = 8,
  parameter int WORD_WIDTH  = 64,
  parameter int STRING_LEN  = 224,
  parameter int CHANNEL_NUM = 3,
  parameter int STRING_NUM  = 224,
  parameter int HOLD_DATA   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_WIDTH-1:0]        fifo_q_i,
  input  logic                         fifo_empty_i,
  output logic                         fifo_rd_o,
  input  logic                         stall_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o
);

  localparam int BPW       = WORD_WIDTH / DATA_WIDTH;
  localparam int ROW_BYTES = STRING_LEN * CHANNEL_NUM;
  localparam int IDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int COL_W     = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int ROW_W     = (STRING_NUM > 1) ? $clog2(STRING_NUM) : 1;
  localparam int PACE_W    = (HOLD_DATA > 1) ? $clog2(HOLD_DATA) : 1;

  // READ covers the cycle the registered read strobe is high; the word arrives in LOAD.
  typedef enum logic [1:0] {IDLE, READ, LOAD, EMIT} state_t;

  state_t                  state, state_nxt;
  logic                    rd_nxt;
  logic [WORD_WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]        byte_idx;
  logic [PACE_W-1:0]       pace_cnt;
  logic [COL_W-1:0]        col_cnt;
  logic [ROW_W-1:0]        row_cnt;

  logic [WORD_WIDTH-1:0]   cur_word;
  logic [IDX_W-1:0]        cur_idx;
  logic                    can_emit;
  logic                    last_in_word;
  logic                    col_last;
  logic                    row_last;

  // LOAD emits straight from the FIFO data so the first sample costs no extra cycle.
  always_comb begin
    cur_word     = (state == LOAD) ? fifo_q_i : shreg;
    cur_idx      = (state == LOAD) ? '0 : byte_idx;
    can_emit     = ((state == LOAD) || (state == EMIT)) && (pace_cnt == '0) && !stall_i;
    last_in_word = (cur_idx == IDX_W'(BPW - 1));
    col_last     = (col_cnt == COL_W'(ROW_BYTES - 1));
    row_last     = (row_cnt == ROW_W'(STRING_NUM - 1));
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty_i && !stall_i) begin
          rd_nxt    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = LOAD;
      LOAD, EMIT: begin
        state_nxt = EMIT;
        if (can_emit && last_in_word) begin
          if (!fifo_empty_i) begin
            rd_nxt    = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fifo_rd_o    <= 1'b0;
      shreg        <= '0;
      byte_idx     <= '0;
      pace_cnt     <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      fifo_rd_o    <= rd_nxt;
      data_valid_o <= can_emit;
      sop_o        <= can_emit && (col_cnt == '0);
      eop_o        <= can_emit && col_last;
      sof_o        <= can_emit && (col_cnt == '0) && (row_cnt == '0);
      eof_o        <= can_emit && col_last && row_last;

      if (state == LOAD) begin
        shreg    <= fifo_q_i;
        byte_idx <= '0;
      end

      if (can_emit) begin
        data_o   <= cur_word[DATA_WIDTH-1:0];
        shreg    <= cur_word >> DATA_WIDTH;
        byte_idx <= cur_idx + IDX_W'(1);
        pace_cnt <= PACE_W'(HOLD_DATA - 1);
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end else if (pace_cnt != '0) begin
        pace_cnt <= pace_cnt - PACE_W'(1);
      end
    end
  end

endmodule
